data_sync_tx: RTL and testbench

//  Source-domain launcher for the multi-bit enable-qualified CDC path. Accepts a word via

---
 rtl/data_sync_tx.sv | 150 +++++++++++++++
 tb/tb_data_sync_tx.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/data_sync_tx.sv
// Source-side launcher for an enable-qualified multi-bit CDC path; optional DATA_SYNC_TX_ACK_EN swaps the hold/gap timers for a four-phase ack.
// Latency: Unsync_bus/bus_enable update on the accept edge; src_ready is combinational and low for the whole HOLD+GAP window.
`timescale 1ns/1ps

module data_sync_tx #(
    parameter int BUS_WIDTH   = 8,
    parameter int NUM_STAGES  = 2,
    parameter int HOLD_CYCLES = 6,
    parameter int GAP_CYCLES  = 6
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic [BUS_WIDTH-1:0] src_data,
    input  logic                 src_valid,
    output logic                 src_ready,
    output logic [BUS_WIDTH-1:0] Unsync_bus,
    output logic                 bus_enable,
    output logic                 busy,
    input  logic                 ack_async
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HOLD = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [BUS_WIDTH-1:0] bus_q, bus_d;
    logic                 en_q, en_d;
    logic                 busy_q, busy_d;
    logic                 hold_done, gap_done;
    logic                 enter_hold, enter_gap;

`ifdef DATA_SYNC_TX_ACK_EN
    logic [NUM_STAGES-1:0] ack_sync_q, ack_sync_d;
    logic                  ack_s;
    logic                  unused_cfg;

    // Timer lengths play no part when the destination paces the handshake.
    assign unused_cfg = (HOLD_CYCLES > 0) ^ (GAP_CYCLES > 0) ^ enter_hold ^ enter_gap;

    always_comb begin
        ack_sync_d = (ack_sync_q << 1) | NUM_STAGES'(ack_async);
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            ack_sync_q <= '0;
        end else begin
            ack_sync_q <= ack_sync_d;
        end
    end

    assign ack_s     = ack_sync_q[NUM_STAGES-1];
    assign hold_done = ack_s;
    assign gap_done  = !ack_s;
`else
    localparam int MAX_CYC = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CYC) + 1;
    localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'(GAP_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             unused_ack;

    assign unused_ack = ack_async & (NUM_STAGES > 0);

    // Reloaded on every state entry, so it only ever counts down to zero.
    always_comb begin
        cnt_d = cnt_q;
        if (enter_hold) begin
            cnt_d = HOLD_LOAD;
        end else if (enter_gap) begin
            cnt_d = GAP_LOAD;
        end else if ((state_q == ST_HOLD || state_q == ST_GAP) && cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign hold_done = (cnt_q == '0);
    assign gap_done  = (cnt_q == '0);
`endif

    always_comb begin
        state_d    = state_q;
        bus_d      = bus_q;
        en_d       = en_q;
        busy_d     = busy_q;
        enter_hold = 1'b0;
        enter_gap  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (src_valid) begin
                    bus_d      = src_data;
                    en_d       = 1'b1;
                    busy_d     = 1'b1;
                    state_d    = ST_HOLD;
                    enter_hold = 1'b1;
                end
            end
            ST_HOLD: begin
                if (hold_done) begin
                    en_d      = 1'b0;
                    state_d   = ST_GAP;
                    enter_gap = 1'b1;
                end
            end
            ST_GAP: begin
                if (gap_done) begin
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                en_d    = 1'b0;
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= ST_IDLE;
            bus_q   <= '0;
            en_q    <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            bus_q   <= bus_d;
            en_q    <= en_d;
            busy_q  <= busy_d;
        end
    end

    assign src_ready  = (state_q == ST_IDLE);
    assign Unsync_bus = bus_q;
    assign bus_enable = en_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_data_sync_tx.sv
// Bench for data_sync_tx: timeline model of the enable waveform plus directed vectors and a slow-domain receiver.
`timescale 1ns/1ps

module tb_data_sync_tx;

    localparam int HC  = 6;
    localparam int GC  = 6;
    localparam int HC2 = 13;
    localparam int GC2 = 13;

    logic       CLK = 1'b0;
    logic       DCLK = 1'b0;
    logic       RST = 1'b0;
    logic [7:0] src_data = '0;
    logic       src_valid = 1'b0;
    logic       src_ready;
    logic [7:0] Unsync_bus;
    logic       bus_enable;
    logic       busy;

    logic [7:0] d2_data = '0;
    logic       d2_valid = 1'b0;
    logic       d2_ready;
    logic [7:0] d2_bus;
    logic       d2_en;
    logic       d2_busy;

    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;
    always #15 DCLK = ~DCLK;

    data_sync_tx #(.BUS_WIDTH(8), .NUM_STAGES(2), .HOLD_CYCLES(HC), .GAP_CYCLES(GC)) dut (
        .CLK(CLK), .RST(RST), .src_data(src_data), .src_valid(src_valid), .src_ready(src_ready),
        .Unsync_bus(Unsync_bus), .bus_enable(bus_enable), .busy(busy), .ack_async(1'b0)
    );

    // Second instance sized so each level spans more than NUM_STAGES+2 destination periods.
    data_sync_tx #(.BUS_WIDTH(8), .NUM_STAGES(2), .HOLD_CYCLES(HC2), .GAP_CYCLES(GC2)) dut2 (
        .CLK(CLK), .RST(RST), .src_data(d2_data), .src_valid(d2_valid), .src_ready(d2_ready),
        .Unsync_bus(d2_bus), .bus_enable(d2_en), .busy(d2_busy), .ack_async(1'b0)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a word accepted at edge n drives enable for edges n..n+HC-1, busy until n+HC+GC.
    int         cyc = 0;
    int         m_acc = 0;
    bit         m_active = 1'b0;
    logic [7:0] m_bus = '0;
    int         acc_q[$];

    always @(posedge CLK or negedge RST) begin
        if (!RST) begin
            m_active = 1'b0;
            m_bus    = '0;
        end else begin
            if (src_valid && src_ready) acc_q.push_back(cyc + 1);
            if (src_valid && (!m_active || (cyc - m_acc >= HC + GC))) begin
                m_acc    = cyc + 1;
                m_active = 1'b1;
                m_bus    = src_data;
            end
            cyc = cyc + 1;
        end
    end

    always @(negedge CLK) begin
        automatic int k     = cyc - m_acc;
        automatic bit e_en  = m_active && (k < HC);
        automatic bit e_bsy = m_active && (k < HC + GC);
        chk("bus", Unsync_bus, m_bus);
        chk("enable", bus_enable, e_en);
        chk("busy", busy, e_bsy);
        chk("ready", src_ready, !e_bsy);
    end

    // Destination side: two-flop enable synchroniser, load the bus on the synchronised rising edge.
    logic s1 = 1'b0, s2 = 1'b0, s3 = 1'b0;
    logic [7:0] rx_q[$];
    always @(posedge DCLK or negedge RST) begin
        if (!RST) begin
            s1 <= 1'b0; s2 <= 1'b0; s3 <= 1'b0;
        end else begin
            s1 <= d2_en; s2 <= s1; s3 <= s2;
            if (s2 && !s3) rx_q.push_back(d2_bus);
        end
    end

    // Called at a negedge; returns just after the accepting posedge, src_valid left high.
    task automatic send(input logic [7:0] w);
        bit ok = 1'b0;
        src_data  = w;
        src_valid = 1'b1;
        for (int t = 0; t < 60; t++) begin
            if (src_ready) begin ok = 1'b1; break; end
            @(negedge CLK);
        end
        if (ok) @(posedge CLK);
        else chk("send_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int hi, lo, nr;
        logic [7:0] sent[$];
        // Reset with random inputs.
        repeat (4) begin
            @(negedge CLK);
            src_valid = 1'b1;
            src_data  = 8'($urandom);
        end
        chk("rst_bus", Unsync_bus, 8'h00);
        chk("rst_en", bus_enable, 1'b0);
        chk("rst_busy", busy, 1'b0);
        @(negedge CLK);
        src_valid = 1'b0;
        RST = 1'b1;
        @(negedge CLK);
        chk("rdy_after_rst", src_ready, 1'b1);

        // Single word, waveform lengths.
        send(8'hA5);
        @(negedge CLK);
        src_valid = 1'b0;
        hi = 0; lo = 0; nr = 0;
        for (int i = 0; i < 20; i++) begin
            if (bus_enable) hi++;
            if (!bus_enable && !src_ready) lo++;
            if (!src_ready) nr++;
            @(negedge CLK);
        end
        chk("hold_len", hi, 6);
        chk("gap_len", lo, 6);
        chk("notready_len", nr, 12);
        chk("bus_a5", Unsync_bus, 8'hA5);

        // Back-to-back with valid held.
        acc_q.delete();
        send(8'h01);
        @(negedge CLK);
        send(8'h02);
        @(negedge CLK);
        src_valid = 1'b0;
        chk("b2b_count", acc_q.size(), 2);
        if (acc_q.size() >= 2) chk("b2b_spacing", acc_q[1] - acc_q[0], 13);
        chk("b2b_bus", Unsync_bus, 8'h02);

        // Data toggling while busy is ignored.
        repeat (3) @(negedge CLK);
        send(8'h3C);
        for (int i = 0; i < 12; i++) begin
            @(negedge CLK);
            src_data = (i % 2) ? 8'h5A : 8'hF0;
            if (i == 5) chk("busy_bus_3c", Unsync_bus, 8'h3C);
        end
        @(negedge CLK);
        src_data = 8'h99;
        @(posedge CLK);
        @(negedge CLK);
        src_valid = 1'b0;
        chk("after_busy_bus", Unsync_bus, 8'h99);
        repeat (14) @(negedge CLK);

        // Asynchronous reset in the third HOLD cycle.
        send(8'hE7);
        src_valid = 1'b0;
        @(posedge CLK);
        @(posedge CLK);
        #2 RST = 1'b0;
        #1;
        chk("arst_en", bus_enable, 1'b0);
        chk("arst_bus", Unsync_bus, 8'h00);
        chk("arst_busy", busy, 1'b0);
        chk("arst_rdy", src_ready, 1'b1);
        @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        send(8'h77);
        @(negedge CLK);
        src_valid = 1'b0;
        chk("restart_bus", Unsync_bus, 8'h77);
        chk("restart_en", bus_enable, 1'b1);
        repeat (14) @(negedge CLK);

        // End to end with a destination clock three times slower.
        for (int i = 0; i < 100; i++) begin
            bit ok = 1'b0;
            logic [7:0] w = 8'($urandom);
            sent.push_back(w);
            @(negedge CLK);
            d2_data  = w;
            d2_valid = 1'b1;
            for (int t = 0; t < 80; t++) begin
                if (d2_ready) begin ok = 1'b1; break; end
                @(negedge CLK);
            end
            if (!ok) chk("e2e_send_timeout", 32'd0, 32'd1);
            @(posedge CLK);
            @(negedge CLK);
            d2_valid = 1'b0;
            d2_data  = 8'($urandom);
        end
        repeat (300) @(negedge CLK);
        chk("e2e_count", rx_q.size(), 100);
        for (int i = 0; i < 100; i++) begin
            if (i < rx_q.size()) chk("e2e_word", rx_q[i], sent[i]);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
